coin_acceptor: RTL

- Upstream feeder for the coffee vending core.
- Debounces the two raw coin-slot sensors: small coin = 1 unit, large coin = 5 units.
- Checks each coin against the remaining credit headroom. Accepted coins become a burst of single-cycle Input_Money pulses; rejected coins raise Coin_Return.
- Guarantees the core's Money register never exceeds MAX_CREDIT.

---
 rtl/vending_pkg.sv | 17 +
 rtl/coin_debounce.sv | 43 ++++
 rtl/coin_acceptor.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/vending_pkg.sv
// Shared definitions for the coffee vending datapath.
// Holds the credit ceiling and large-coin value used by both the vending
// core and the coin acceptor, plus the acceptor FSM encoding.
package vending_pkg;

    localparam int unsigned MAX_CREDIT  = 16;
    localparam int unsigned LARGE_VALUE = 5;
    localparam int unsigned MONEY_W     = 5;
    localparam int unsigned SUM_W       = 6;

    typedef enum logic [1:0] {
        ACC_IDLE   = 2'b00,
        ACC_FEED   = 2'b01,
        ACC_REJECT = 2'b10
    } acc_state_t;

endpackage

// File: rtl/coin_debounce.sv
// Per-sensor debouncer for a raw coin-slot sensor.
// Ports:
//   Clock, nReset : clock (rising edge), asynchronous active-low reset
//   sensor        : raw sensor level, synchronous to Clock, may bounce
//   qual_c        : one-cycle pulse in the cycle a coin becomes qualified
// A coin qualifies after DEBOUNCE_CYCLES consecutive high cycles; the sensor
// is then disarmed until it has been low for DEBOUNCE_CYCLES consecutive cycles.
module coin_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 3
) (
    input  logic Clock,
    input  logic nReset,
    input  logic sensor,
    output logic qual_c
);

    localparam int unsigned            CNT_W    = 3;
    localparam logic [CNT_W-1:0]       CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic             armed_q;
    logic             level_hit_c;

    // Armed: count highs toward a qualification. Disarmed: count lows toward re-arm.
    assign level_hit_c = armed_q ? sensor : ~sensor;
    assign qual_c      = armed_q & sensor & (cnt_q == CNT_LAST);

    // Run-length counter; a completed run toggles the arm state.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            cnt_q   <= '0;
            armed_q <= 1'b1;
        end else if (!level_hit_c) begin
            cnt_q   <= '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_q   <= '0;
            armed_q <= ~armed_q;
        end else begin
            cnt_q   <= cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/coin_acceptor.sv
// Coin acceptor feeding the coffee vending core.
// Ports:
//   Clock, nReset          : clock (rising edge), asynchronous active-low reset
//   Coin_Small, Coin_Large : raw coin sensors (1 unit / LARGE_VALUE units)
//   Money                  : current credit held by the vending core
//   Vend_Idle              : core is in NORMAL and counts Input_Money
//   Input_Money            : one-cycle pulse, one credit unit each
//   Coin_Return            : one-cycle pulse ejecting a rejected coin
//   Return_Large           : qualifies Coin_Return, 1 = large coin ejected
//   Accept_Busy            : credit pending or a qualified coin unevaluated
// Coins are accepted only if the core's credit can never exceed MAX_CREDIT.
module coin_acceptor
    import vending_pkg::MONEY_W, vending_pkg::SUM_W, vending_pkg::acc_state_t,
           vending_pkg::ACC_IDLE, vending_pkg::ACC_FEED, vending_pkg::ACC_REJECT;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 3,
    parameter int unsigned MAX_CREDIT      = vending_pkg::MAX_CREDIT,
    parameter int unsigned LARGE_VALUE     = vending_pkg::LARGE_VALUE
) (
    input  logic               Clock,
    input  logic               nReset,
    input  logic               Coin_Small,
    input  logic               Coin_Large,
    input  logic [MONEY_W-1:0] Money,
    input  logic               Vend_Idle,
    output logic               Input_Money,
    output logic               Coin_Return,
    output logic               Return_Large,
    output logic               Accept_Busy
);

    logic               small_qual_c;
    logic               large_qual_c;

    acc_state_t         state_q;
    acc_state_t         state_d;
    logic [MONEY_W-1:0] pending_q;
    logic [MONEY_W-1:0] pending_d;
    logic               small_evt_q;
    logic               small_evt_d;
    logic               large_evt_q;
    logic               large_evt_d;

    logic               deliver_c;
    logic               eval_large_c;
    logic               eval_small_c;
    logic               fits_c;
    logic               accept_c;
    logic               reject_c;
    logic [MONEY_W-1:0] coin_val_c;
    logic [MONEY_W-1:0] pend_after_emit_c;
    logic [SUM_W-1:0]   credit_sum_c;

    logic               input_money_d;
    logic               coin_return_d;
    logic               return_large_d;
    logic               accept_busy_d;

    coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_small_deb (
        .Clock  (Clock),
        .nReset (nReset),
        .sensor (Coin_Small),
        .qual_c (small_qual_c)
    );

    coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_large_deb (
        .Clock  (Clock),
        .nReset (nReset),
        .sensor (Coin_Large),
        .qual_c (large_qual_c)
    );

    // FSM state register.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state_q <= ACC_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Evaluation, pending credit, event flags, next state and next outputs.
    always_comb begin
        state_d           = state_q;
        deliver_c         = Input_Money & Vend_Idle;
        eval_large_c      = (state_q != ACC_REJECT) & large_evt_q;
        eval_small_c      = (state_q != ACC_REJECT) & ~large_evt_q & small_evt_q;
        coin_val_c        = eval_large_c ? MONEY_W'(LARGE_VALUE) : MONEY_W'(1);
        credit_sum_c      = SUM_W'(Money) + SUM_W'(pending_q) + SUM_W'(coin_val_c);
        fits_c            = (credit_sum_c <= SUM_W'(MAX_CREDIT));
        accept_c          = (eval_large_c | eval_small_c) & fits_c;
        reject_c          = (eval_large_c | eval_small_c) & ~fits_c;

        // Pending drops on the same edge the core counts the pulse, so
        // Money + Pending stays exact for the headroom check.
        pend_after_emit_c = pending_q - MONEY_W'(deliver_c);
        pending_d         = pend_after_emit_c + (accept_c ? coin_val_c : MONEY_W'(0));

        // A fresh qualification wins over clearing the evaluated flag.
        large_evt_d       = (large_evt_q & ~eval_large_c) | large_qual_c;
        small_evt_d       = (small_evt_q & ~eval_small_c) | small_qual_c;

        if (reject_c) begin
            state_d = ACC_REJECT;
        end else begin
            case (state_q)
                ACC_IDLE:   if (pending_d != '0) state_d = ACC_FEED;
                ACC_FEED:   if ((pending_d == '0) && !small_evt_d && !large_evt_d) state_d = ACC_IDLE;
                ACC_REJECT: state_d = (pending_d != '0) ? ACC_FEED : ACC_IDLE;
                default:    state_d = ACC_IDLE;
            endcase
        end

        // Next pulse only if credit remains after the one currently in flight.
        input_money_d     = Vend_Idle & (pend_after_emit_c != '0);
        coin_return_d     = (state_d == ACC_REJECT);
        return_large_d    = reject_c & eval_large_c;
        accept_busy_d     = (pending_d != '0) | small_evt_d | large_evt_d;
    end

    // Datapath and output registers.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            pending_q    <= '0;
            small_evt_q  <= 1'b0;
            large_evt_q  <= 1'b0;
            Input_Money  <= 1'b0;
            Coin_Return  <= 1'b0;
            Return_Large <= 1'b0;
            Accept_Busy  <= 1'b0;
        end else begin
            pending_q    <= pending_d;
            small_evt_q  <= small_evt_d;
            large_evt_q  <= large_evt_d;
            Input_Money  <= input_money_d;
            Coin_Return  <= coin_return_d;
            Return_Large <= return_large_d;
            Accept_Busy  <= accept_busy_d;
        end
    end

endmodule
